// File: rtl/bcd_load_scheduler.sv
// Round-robin frame loader for the BCD accumulator: grant, clear, stream NUM_DIGITS sanitised digits.
// Optional stall watchdog enabled by defining BCDSEQ_TIMEOUT_EN.
module bcd_load_scheduler #(
    parameter int NUM_DIGITS = 300,
    parameter int CNT_W      = 9,
    parameter int TIMEOUT    = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       dig_valid,
    input  logic [3:0]       dig_data_0,
    input  logic [3:0]       dig_data_1,
    output logic [1:0]       gnt,
    output logic [1:0]       dig_ready,
    output logic             sr_clear,
    output logic             sr_shift,
    output logic [3:0]       sr_digit,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output logic             done_id,
    output logic             bad_digit,
    output logic             abort
);

    if (NUM_DIGITS < 2 || (1 << CNT_W) <= NUM_DIGITS || TIMEOUT < 1) begin : g_param_chk
        $error("bcd_load_scheduler: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;

    state_t     state, state_nxt;
    logic       g;
    logic       last_id;
    logic       win_id;
    logic       accept;
    logic       last_digit;
    logic       stall_hit;
    logic [3:0] cur_data;

    assign g = gnt[1];

    // Tie goes to whoever was not served last; last_id resets to 1 so requester 0 wins first.
    assign win_id = (req == 2'b11) ? ~last_id : req[1];

    always_comb begin
        cur_data   = g ? dig_data_1 : dig_data_0;
        dig_ready  = (state == LOAD) ? gnt : 2'b00;
        accept     = |(dig_valid & dig_ready);
        sr_shift   = accept;
        sr_digit   = (accept && cur_data <= 4'd9) ? cur_data : 4'd0;
        sr_clear   = (state == CLEAR);
        busy       = (state != IDLE);
        done       = (state == DONE);
        last_digit = accept && (count == CNT_W'(NUM_DIGITS - 1));
    end

`ifdef BCDSEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] stall;
    logic          abort_q;

    assign stall_hit = (state == LOAD) && !accept && (stall == TW'(TIMEOUT - 1));
    assign abort     = done & abort_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall   <= '0;
            abort_q <= 1'b0;
        end else begin
            if (state != LOAD || accept) stall <= '0;
            else                         stall <= stall + 1'b1;
            if (state == LOAD)           abort_q <= stall_hit;
        end
    end
`else
    assign stall_hit = 1'b0;
    assign abort     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req != 2'b00) state_nxt = CLEAR;
            CLEAR:   state_nxt = LOAD;
            LOAD:    if (last_digit || stall_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt       <= 2'b00;
            last_id   <= 1'b1;
            count     <= '0;
            done_id   <= 1'b0;
            bad_digit <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req != 2'b00) gnt <= win_id ? 2'b10 : 2'b01;
                CLEAR: begin
                    count     <= '0;
                    bad_digit <= 1'b0;
                end
                LOAD: begin
                    if (accept) begin
                        count <= count + 1'b1;
                        if (cur_data > 4'd9) bad_digit <= 1'b1;
                    end
                    // done_id is visible during the DONE cycle itself
                    if (last_digit || stall_hit) done_id <= g;
                end
                DONE: begin
                    gnt     <= 2'b00;
                    last_id <= g;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_load_scheduler.sv
// Directed bench for bcd_load_scheduler with a digit scoreboard on the accumulator port.
module tb_bcd_load_scheduler;

    localparam int N = 300;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req, dig_valid, gnt, dig_ready;
    logic [3:0] dig_data_0, dig_data_1, sr_digit;
    logic       sr_clear, sr_shift, busy, done, done_id, bad_digit, abort;
    logic [8:0] count;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];

    bcd_load_scheduler #(.NUM_DIGITS(N), .CNT_W(9), .TIMEOUT(1023)) dut (
        .clk(clk), .reset(reset), .req(req), .dig_valid(dig_valid),
        .dig_data_0(dig_data_0), .dig_data_1(dig_data_1), .gnt(gnt),
        .dig_ready(dig_ready), .sr_clear(sr_clear), .sr_shift(sr_shift),
        .sr_digit(sr_digit), .busy(busy), .count(count), .done(done),
        .done_id(done_id), .bad_digit(bad_digit), .abort(abort)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every shift must match the next expected sanitised digit.
    always @(negedge clk) begin
        if (!reset) begin
            if (sr_shift) begin
                if (exp_q.size() == 0) check("extra_shift", 32'(sr_digit), 32'hFFFF);
                else                   check("sr_digit", 32'(sr_digit), 32'(exp_q.pop_front()));
            end else begin
                check("sr_digit_idle", 32'(sr_digit), 32'h0);
            end
        end
    end

    task automatic frame(input logic [1:0] r, input int w, input int bad_pos,
                         input bit gap, input bit other, input int stop_at);
        logic [3:0] d;
        @(posedge clk); #1 req = r;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("clr_gnt", 32'(gnt), 32'(2'b01 << w));
        check("clr_pulse", 32'(sr_clear), 32'h1);
        check("clr_busy", 32'(busy), 32'h1);
        check("clr_ready", 32'(dig_ready), 32'h0);
        for (int k = 0; k < stop_at; k++) begin
            @(posedge clk); #1;
            if (gap && k == 100) begin
                dig_valid[w] = 1'b0;
                req = 2'b00;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("gap_ready", 32'(dig_ready), 32'(2'b01 << w));
                    check("gap_shift", 32'(sr_shift), 32'h0);
                    @(posedge clk); #1;
                end
            end
            d = (k == bad_pos) ? 4'hC : 4'(k % 10);
            dig_valid[w]     = 1'b1;
            dig_valid[1 - w] = other;
            if (w == 0) begin dig_data_0 = d; dig_data_1 = 4'h7; end
            else        begin dig_data_1 = d; dig_data_0 = 4'h7; end
            exp_q.push_back((d > 4'd9) ? 4'd0 : d);
            if (k == 0) begin
                @(negedge clk);
                check("load0_bad", 32'(bad_digit), 32'h0);
                check("load0_count", 32'(count), 32'h0);
            end
        end
        if (stop_at < N) begin
            @(posedge clk); #1 reset = 1'b1; dig_valid = 2'b00; req = 2'b00;
            @(negedge clk);
            check("pre_rst_count", 32'(count), 32'(stop_at));
            @(posedge clk); #1 reset = 1'b0;
            @(negedge clk);
            check("mid_rst_outs", 32'({gnt, dig_ready, sr_clear, sr_shift, sr_digit, busy,
                                       count, done, done_id, bad_digit, abort}), 32'h0);
            check("mid_rst_q", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
            return;
        end
        @(posedge clk); #1 dig_valid = 2'b00; req = 2'b00;
        @(negedge clk);
        check("done_pulse", 32'(done), 32'h1);
        check("done_id", 32'(done_id), 32'(w));
        check("done_count", 32'(count), 32'(N));
        check("done_bad", 32'(bad_digit), 32'(bad_pos >= 0));
        check("done_gnt", 32'(gnt), 32'(2'b01 << w));
        check("done_abort", 32'(abort), 32'h0);
        check("done_q_empty", 32'(exp_q.size()), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_done", 32'(done), 32'h0);
        check("post_busy", 32'(busy), 32'h0);
        check("post_gnt", 32'(gnt), 32'h0);
        check("post_count", 32'(count), 32'(N));
        check("post_bad", 32'(bad_digit), 32'(bad_pos >= 0));
    endtask

    initial begin
        reset = 1'b1; req = 2'b00; dig_valid = 2'b00; dig_data_0 = 4'h0; dig_data_1 = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outs", 32'({gnt, dig_ready, sr_clear, sr_shift, sr_digit, busy,
                               count, done, done_id, bad_digit, abort}), 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        frame(2'b11, 0, -1, 1'b0, 1'b0, N);
        frame(2'b11, 1, -1, 1'b0, 1'b0, N);
        frame(2'b11, 0, -1, 1'b0, 1'b0, N);
        frame(2'b01, 0, 5, 1'b0, 1'b0, N);
        frame(2'b01, 0, -1, 1'b1, 1'b1, N);
        frame(2'b01, 0, -1, 1'b0, 1'b0, 150);
        frame(2'b10, 1, -1, 1'b0, 1'b0, N);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
